// File: rtl/harq_send_reader.sv
`timescale 1ns/1ps
// harq_send_reader
// Drains one user's combined LLR block from the COMB ping or pong SRAM and
// streams it to the HARQ memory write port over valid/ready. A one-cycle
// o_SENDHARQ_Data_Comp pulse marks completion of the block.
//
// Ports:
//   i_core_clk, i_rx_rstn          clock, asynchronous active-low reset
//   i_Send_request/_buffer_sel/_user_index
//                                  start pulse, ping(0)/pong(1), user index
//   i_users_ncb                    8 x 16-bit Ncb, user u at [16u+15:16u]
//   o_Ping/Pong_Read_En, o_Buffer_Read_Addr
//                                  SRAM read port (data returns 1 cycle later)
//   DualPort_SRAM_COMB_*_Read_Data ping/pong read data
//   o_HARQ_Data_Valid/_Content/_Last, i_HARQ_Data_Ready
//                                  output stream
//   o_SENDHARQ_Data_Comp           block-done pulse
//   o_Send_busy                    block in progress (through the Comp cycle)
module harq_send_reader #(
   parameter int ADDR_W = 10,   // must be <= 12
   parameter int LANES  = 16,
   parameter int LLR_W  = 10
) (
   input  logic                     i_core_clk,
   input  logic                     i_rx_rstn,
   input  logic                     i_Send_request,
   input  logic                     i_Send_buffer_sel,
   input  logic [3:0]               i_Send_user_index,
   input  logic [127:0]             i_users_ncb,
   output logic                     o_Ping_Read_En,
   output logic                     o_Pong_Read_En,
   output logic [ADDR_W-1:0]        o_Buffer_Read_Addr,
   input  logic [LANES*LLR_W-1:0]   DualPort_SRAM_COMB_Ping_Buffer_Read_Data,
   input  logic [LANES*LLR_W-1:0]   DualPort_SRAM_COMB_Pong_Buffer_Read_Data,
   output logic                     o_HARQ_Data_Valid,
   output logic [LANES*LLR_W-1:0]   o_HARQ_Data_Content,
   output logic                     o_HARQ_Data_Last,
   input  logic                     i_HARQ_Data_Ready,
   output logic                     o_SENDHARQ_Data_Comp,
   output logic                     o_Send_busy
);
   localparam int W = LANES * LLR_W;
   localparam logic [12:0]     N_MAX_WIDE = 13'(2 ** ADDR_W);
   localparam logic [ADDR_W:0] N_MAX      = (ADDR_W + 1)'(2 ** ADDR_W);
   localparam logic [ADDR_W:0] ONE        = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;
   state_t state_reg, state_next;

   logic              sel_reg;
   logic [ADDR_W:0]   n_reg, rd_cnt_reg, cap_cnt_reg;
   logic [3:0]        rem_reg;
   logic              inflight_reg;
   logic [W-1:0]      fifo_data [0:1];
   logic [1:0]        fifo_last_reg;
   logic              wr_ptr_reg, rd_ptr_reg;
   logic [1:0]        count_reg, count_next;

   // ---------------- request decode ----------------
   logic [15:0]       req_ncb;
   logic [16:0]       ncb_sum;
   logic [12:0]       n_raw;
   logic [ADDR_W:0]   req_n;
   logic              req_accept;

   assign req_ncb    = i_Send_user_index[3] ? 16'd0
                     : i_users_ncb[{i_Send_user_index[2:0], 4'b0000} +: 16];
   assign ncb_sum    = {1'b0, req_ncb} + 17'd15;
   assign n_raw      = ncb_sum[16:4];
   assign req_n      = (n_raw > N_MAX_WIDE) ? N_MAX : n_raw[ADDR_W:0];
   assign req_accept = i_Send_request && (state_reg == ST_IDLE);

   // ---------------- read issue ----------------
   // Buffered words plus the word still coming back from the SRAM never
   // exceed the two FIFO slots, so a returning word always has a home.
   logic [2:0] occupancy;
   logic       rd_en;
   assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg};
   assign rd_en     = (state_reg == ST_READ) && (occupancy < 3'd2);

   assign o_Ping_Read_En     = rd_en && !sel_reg;
   assign o_Pong_Read_En     = rd_en &&  sel_reg;
   assign o_Buffer_Read_Addr = rd_cnt_reg[ADDR_W-1:0];

   // ---------------- capture and last-word masking ----------------
   logic [W-1:0] raw_word, in_word;
   logic         cap_last, mask_en;
   assign raw_word = sel_reg ? DualPort_SRAM_COMB_Pong_Buffer_Read_Data
                             : DualPort_SRAM_COMB_Ping_Buffer_Read_Data;
   assign cap_last = (cap_cnt_reg == n_reg - ONE);
   assign mask_en  = cap_last && (rem_reg != 4'd0);

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         localparam logic [4:0] LANE_IDX = 5'(gi);
         assign in_word[gi*LLR_W +: LLR_W] =
            (mask_en && (LANE_IDX >= {1'b0, rem_reg})) ? '0
                                                       : raw_word[gi*LLR_W +: LLR_W];
      end
   endgenerate

   // ---------------- output FIFO (fall-through) ----------------
   // With the FIFO empty, the word returning from the SRAM is presented
   // directly; it is stored only if it is not accepted in that cycle.
   logic         fifo_nonempty, head_last, xfer, push, pop;
   logic [W-1:0] head_data;
   assign fifo_nonempty = (count_reg != 2'd0);
   assign head_data     = fifo_nonempty ? fifo_data[rd_ptr_reg] : in_word;
   assign head_last     = fifo_nonempty ? fifo_last_reg[rd_ptr_reg] : cap_last;

   assign o_HARQ_Data_Valid   = fifo_nonempty || inflight_reg;
   assign o_HARQ_Data_Content = o_HARQ_Data_Valid ? head_data : '0;
   assign o_HARQ_Data_Last    = o_HARQ_Data_Valid && head_last;
   assign xfer = o_HARQ_Data_Valid && i_HARQ_Data_Ready;
   assign push = inflight_reg && !(!fifo_nonempty && xfer);
   assign pop  = xfer && fifo_nonempty;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge i_core_clk) begin
      if (push) fifo_data[wr_ptr_reg] <= in_word;
   end

   // ---------------- FSM ----------------
   always_comb begin
      state_next           = state_reg;
      o_SENDHARQ_Data_Comp = 1'b0;
      case (state_reg)
         ST_IDLE:  if (req_accept) state_next = (req_n != '0) ? ST_READ : ST_DONE;
         ST_READ:  if (rd_en && (rd_cnt_reg == n_reg - ONE)) state_next = ST_DRAIN;
         ST_DRAIN: if (xfer && head_last) state_next = ST_DONE;
         ST_DONE: begin
            o_SENDHARQ_Data_Comp = 1'b1;
            state_next           = ST_IDLE;
         end
         default:  state_next = ST_IDLE;
      endcase
   end

   assign o_Send_busy = (state_reg != ST_IDLE);

   always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
      if (!i_rx_rstn) begin
         state_reg     <= ST_IDLE;
         sel_reg       <= 1'b0;
         n_reg         <= '0;
         rem_reg       <= 4'd0;
         rd_cnt_reg    <= '0;
         cap_cnt_reg   <= '0;
         inflight_reg  <= 1'b0;
         fifo_last_reg <= 2'b00;
         wr_ptr_reg    <= 1'b0;
         rd_ptr_reg    <= 1'b0;
         count_reg     <= 2'd0;
      end else begin
         state_reg    <= state_next;
         inflight_reg <= rd_en;
         count_reg    <= count_next;
         if (req_accept) begin
            sel_reg     <= i_Send_buffer_sel;
            n_reg       <= req_n;
            rem_reg     <= req_ncb[3:0];
            rd_cnt_reg  <= '0;
            cap_cnt_reg <= '0;
         end else begin
            if (rd_en)        rd_cnt_reg  <= rd_cnt_reg + ONE;
            if (inflight_reg) cap_cnt_reg <= cap_cnt_reg + ONE;
         end
         if (push) begin
            fifo_last_reg[wr_ptr_reg] <= cap_last;
            wr_ptr_reg                <= !wr_ptr_reg;
         end
         if (pop) rd_ptr_reg <= !rd_ptr_reg;
      end
   end
endmodule

// File: tb/tb_harq_send_reader.sv
`timescale 1ns/1ps
module tb_harq_send_reader;
   logic         tb_sclk = 1'b0;
   logic         i_rx_rstn;
   logic         i_Send_request = 1'b0;
   logic         i_Send_buffer_sel = 1'b0;
   logic [3:0]   i_Send_user_index = 4'd0;
   logic [127:0] i_users_ncb;
   logic         o_Ping_Read_En, o_Pong_Read_En;
   logic [9:0]   o_Buffer_Read_Addr;
   logic [159:0] ping_rd = '0, pong_rd = '0;
   logic         o_HARQ_Data_Valid, o_HARQ_Data_Last;
   logic [159:0] o_HARQ_Data_Content;
   logic         i_HARQ_Data_Ready;
   logic         o_SENDHARQ_Data_Comp, o_Send_busy;

   harq_send_reader dut (
      .i_core_clk                               (tb_sclk),
      .i_rx_rstn                                (i_rx_rstn),
      .i_Send_request                           (i_Send_request),
      .i_Send_buffer_sel                        (i_Send_buffer_sel),
      .i_Send_user_index                        (i_Send_user_index),
      .i_users_ncb                              (i_users_ncb),
      .o_Ping_Read_En                           (o_Ping_Read_En),
      .o_Pong_Read_En                           (o_Pong_Read_En),
      .o_Buffer_Read_Addr                       (o_Buffer_Read_Addr),
      .DualPort_SRAM_COMB_Ping_Buffer_Read_Data (ping_rd),
      .DualPort_SRAM_COMB_Pong_Buffer_Read_Data (pong_rd),
      .o_HARQ_Data_Valid                        (o_HARQ_Data_Valid),
      .o_HARQ_Data_Content                      (o_HARQ_Data_Content),
      .o_HARQ_Data_Last                         (o_HARQ_Data_Last),
      .i_HARQ_Data_Ready                        (i_HARQ_Data_Ready),
      .o_SENDHARQ_Data_Comp                     (o_SENDHARQ_Data_Comp),
      .o_Send_busy                              (o_Send_busy)
   );

   initial forever #5 tb_sclk = ~tb_sclk;

   int errors = 0;
   int checks = 0;

   // SRAM models: word k of ping has every lane = k+1, pong every lane = 100+k
   logic [159:0] ping_mem [0:15];
   logic [159:0] pong_mem [0:15];

   function automatic logic [159:0] fill(input int v, input int nl);
      logic [159:0] w;
      w = '0;
      for (int i = 0; i < 16; i++)
         if (i < nl) w[i*10 +: 10] = 10'(v);
      return w;
   endfunction

   initial begin
      for (int k = 0; k < 16; k++) begin
         ping_mem[k] = fill(k + 1, 16);
         pong_mem[k] = fill(100 + k, 16);
      end
   end

   initial forever begin
      @(posedge tb_sclk);
      if (o_Ping_Read_En) ping_rd <= ping_mem[o_Buffer_Read_Addr[3:0]];
      if (o_Pong_Read_En) pong_rd <= pong_mem[o_Buffer_Read_Addr[3:0]];
   end

   // Ready driver: always 1, or the pattern 1,0,0,1,0,1 repeating
   bit       bp_mode = 1'b0;
   logic [5:0] pat = 6'b101001;
   int       pat_idx = 0;
   initial begin
      i_HARQ_Data_Ready = 1'b1;
      forever begin
         @(posedge tb_sclk);
         #1;
         if (bp_mode) begin
            i_HARQ_Data_Ready = pat[pat_idx];
            pat_idx = (pat_idx + 1) % 6;
         end else begin
            i_HARQ_Data_Ready = 1'b1;
            pat_idx = 0;
         end
      end
   end

   // Monitor, sampled on the falling edge
   int           cyc = 0;
   int           req_cyc, first_rd, first_valid, last_xfer_cyc, comp_cyc;
   bit           req_seen;
   int           rd_addr_q [$];
   int           ping_rds, pong_rds, issued, xfers, max_out, comp_cnt;
   logic [159:0] word_q [$];
   logic         last_q [$];
   logic         busy_at_comp;

   task automatic clear_logs();
      req_seen = 0; req_cyc = -1; first_rd = -1; first_valid = -1;
      last_xfer_cyc = -1; comp_cyc = -1; rd_addr_q.delete();
      ping_rds = 0; pong_rds = 0; issued = 0; xfers = 0; max_out = 0;
      comp_cnt = 0; word_q.delete(); last_q.delete(); busy_at_comp = 1'b0;
   endtask

   initial forever begin
      @(negedge tb_sclk);
      cyc++;
      if (i_Send_request && !req_seen) begin req_seen = 1; req_cyc = cyc; end
      if (o_Ping_Read_En) begin
         ping_rds++;
         rd_addr_q.push_back(int'(o_Buffer_Read_Addr));
      end
      if (o_Pong_Read_En) pong_rds++;
      if ((o_Ping_Read_En || o_Pong_Read_En) && first_rd < 0) first_rd = cyc;
      if (o_Ping_Read_En || o_Pong_Read_En) issued++;
      if (issued - xfers > max_out) max_out = issued - xfers;
      if (o_HARQ_Data_Valid && first_valid < 0) first_valid = cyc;
      if (o_HARQ_Data_Valid && i_HARQ_Data_Ready) begin
         word_q.push_back(o_HARQ_Data_Content);
         last_q.push_back(o_HARQ_Data_Last);
         xfers++;
         last_xfer_cyc = cyc;
      end
      if (o_SENDHARQ_Data_Comp) begin
         comp_cnt++;
         comp_cyc = cyc;
         busy_at_comp = o_Send_busy;
      end
   end

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_req(input logic sel, input logic [3:0] user);
      @(posedge tb_sclk); #1;
      i_Send_request = 1'b1; i_Send_buffer_sel = sel; i_Send_user_index = user;
      @(posedge tb_sclk); #1;
      i_Send_request = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (comp_cnt == 0 && n < 300) begin
         @(posedge tb_sclk);
         n++;
      end
      chk({tag, "_done_in_time"}, (comp_cnt != 0), 1);
      repeat (5) @(posedge tb_sclk);
      #1;
   endtask

   // Expected result of a ping block with Ncb = 100: N = 7, rem = 4
   task automatic check_ping100(input string tag);
      int lmask;
      chk({tag, "_ping_reads"}, ping_rds, 7);
      chk({tag, "_pong_reads"}, pong_rds, 0);
      for (int k = 0; k < 7 && k < rd_addr_q.size(); k++)
         chk($sformatf("%s_addr%0d", tag, k), rd_addr_q[k], k);
      chk({tag, "_words"}, word_q.size(), 7);
      lmask = 0;
      for (int k = 0; k < 7 && k < word_q.size(); k++) begin
         chk($sformatf("%s_word%0d", tag, k), word_q[k], (k < 6) ? fill(k + 1, 16) : fill(7, 4));
         if (last_q[k] === 1'b1) lmask |= (1 << k);
      end
      chk({tag, "_last_mask"}, lmask, 64);
      chk({tag, "_comp_count"}, comp_cnt, 1);
      chk({tag, "_comp_after_last"}, comp_cyc, last_xfer_cyc + 1);
      chk({tag, "_max_outstanding_le2"}, (max_out <= 2), 1);
      $display("block %s: reads=%0d words=%0d comp_cnt=%0d", tag, ping_rds, word_q.size(), comp_cnt);
   endtask

   initial begin
      int lmask;
      int n;
      i_users_ncb = {8{16'd100}};
      i_rx_rstn = 1'b0;
      clear_logs();
      repeat (3) @(posedge tb_sclk);
      @(negedge tb_sclk);
      chk("rst_valid", o_HARQ_Data_Valid, 0);
      chk("rst_enables", {o_Ping_Read_En, o_Pong_Read_En}, 0);
      chk("rst_comp", o_SENDHARQ_Data_Comp, 0);
      chk("rst_busy", o_Send_busy, 0);
      chk("rst_data", o_HARQ_Data_Content, 0);
      @(posedge tb_sclk); #1;
      i_rx_rstn = 1'b1;
      repeat (2) @(posedge tb_sclk);

      // Basic ping drain, user 1
      clear_logs();
      send_req(1'b0, 4'd1);
      wait_done("basic");
      check_ping100("basic");
      chk("basic_first_read_latency", first_rd, req_cyc + 1);
      chk("basic_first_valid_latency", first_valid, req_cyc + 2);
      chk("basic_busy_at_comp", busy_at_comp, 1);

      // Pong, Ncb = 64 on user 3: 4 words, no masking
      i_users_ncb[63:48] = 16'd64;
      clear_logs();
      send_req(1'b1, 4'd3);
      wait_done("pong");
      chk("pong_ping_reads", ping_rds, 0);
      chk("pong_pong_reads", pong_rds, 4);
      chk("pong_words", word_q.size(), 4);
      lmask = 0;
      for (int k = 0; k < 4 && k < word_q.size(); k++) begin
         chk($sformatf("pong_word%0d", k), word_q[k], fill(100 + k, 16));
         if (last_q[k] === 1'b1) lmask |= (1 << k);
      end
      chk("pong_last_mask", lmask, 8);
      $display("block pong: reads=%0d words=%0d", pong_rds, word_q.size());

      // Backpressure
      bp_mode = 1'b1;
      clear_logs();
      send_req(1'b0, 4'd1);
      wait_done("bp");
      bp_mode = 1'b0;
      check_ping100("bp");

      // Zero Ncb on user 2
      i_users_ncb[47:32] = 16'd0;
      clear_logs();
      send_req(1'b0, 4'd2);
      wait_done("zero");
      chk("zero_reads", ping_rds + pong_rds, 0);
      chk("zero_comp_time", comp_cyc, req_cyc + 1);
      chk("zero_busy_at_comp", busy_at_comp, 1);
      chk("zero_comp_count", comp_cnt, 1);
      $display("block zero: comp at +%0d", comp_cyc - req_cyc);

      // Invalid user index 9
      clear_logs();
      send_req(1'b1, 4'd9);
      wait_done("inv");
      chk("inv_reads", ping_rds + pong_rds, 0);
      chk("inv_words", word_q.size(), 0);
      chk("inv_comp_time", comp_cyc, req_cyc + 1);
      chk("inv_comp_count", comp_cnt, 1);
      $display("block invalid_user: comp at +%0d", comp_cyc - req_cyc);

      // Ignored request mid-block
      clear_logs();
      send_req(1'b0, 4'd1);
      @(posedge tb_sclk);
      send_req(1'b1, 4'd3);
      wait_done("ign");
      check_ping100("ign");

      // Reset mid-block after 3 words
      clear_logs();
      send_req(1'b0, 4'd1);
      n = 0;
      while (xfers < 3 && n < 100) begin
         @(posedge tb_sclk);
         n++;
      end
      chk("rstmid_reached_3", (xfers >= 3), 1);
      #1;
      i_rx_rstn = 1'b0;
      @(negedge tb_sclk);
      chk("rstmid_valid", o_HARQ_Data_Valid, 0);
      chk("rstmid_enables", {o_Ping_Read_En, o_Pong_Read_En}, 0);
      chk("rstmid_busy", o_Send_busy, 0);
      chk("rstmid_last_data", {o_HARQ_Data_Last, o_HARQ_Data_Content}, 0);
      repeat (2) @(posedge tb_sclk);
      #1;
      i_rx_rstn = 1'b1;
      repeat (2) @(posedge tb_sclk);
      clear_logs();
      send_req(1'b0, 4'd1);
      wait_done("rstmid");
      check_ping100("rstmid");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
